// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: freezes on memory wait, squashes on taken branch, bubbles on load-use.
// Optional statistics counters are enabled with `define PIPE_CTRL_STATS_EN.
//   state | meaning
//   RUN   | normal issue; honours mem_busy > branch_taken > stall_req
//   FLUSH | second squash cycle of a taken branch
//   WAIT  | pipeline frozen on multicycle memory; remembers branches in pend_br
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_req,
    input  logic        branch_taken,
    input  logic        mem_busy,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_we,
    output logic [1:0]  state
`ifdef PIPE_CTRL_STATS_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic [15:0] wait_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_FLUSH = 2'b01,
        ST_WAIT  = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   pend_br_q, pend_br_d;
    logic   run_like;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            pend_br_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_br_q <= pend_br_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_br_d = pend_br_q;
        run_like  = 1'b0;
        case (state_q)
            ST_FLUSH: begin
                if (mem_busy) begin
                    state_d   = ST_WAIT;
                    pend_br_d = 1'b1;
                end else begin
                    state_d   = ST_RUN;
                end
            end
            ST_WAIT: begin
                if (mem_busy) begin
                    pend_br_d = pend_br_q | branch_taken;
                end else if (pend_br_q) begin
                    state_d   = ST_FLUSH;
                    pend_br_d = 1'b0;
                end else begin
                    run_like  = 1'b1;
                end
            end
            default: run_like = 1'b1;
        endcase
        // Unused encoding 11 and a clean WAIT exit both take the RUN decision.
        if (run_like) begin
            if (mem_busy) begin
                state_d   = ST_WAIT;
                pend_br_d = branch_taken;
            end else if (branch_taken) begin
                state_d   = ST_FLUSH;
            end else begin
                state_d   = ST_RUN;
            end
        end
    end

    always_comb begin
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        exmem_we   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (!rst_n) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            exmem_we = 1'b0;
        end else if (mem_busy) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            exmem_we = 1'b0;
        end else if (state_q == ST_FLUSH) begin
            ifid_flush = 1'b1;
        end else if ((state_q == ST_WAIT && pend_br_q) || branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (stall_req) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    assign state = state_q;

`ifdef PIPE_CTRL_STATS_EN
    logic stall_hit;
    // pc_we low without a memory wait can only come from a load-use stall.
    assign stall_hit = stall_req && !mem_busy && !pc_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
            wait_cnt  <= 16'd0;
        end else begin
            if (stall_hit && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (state_d == ST_FLUSH && state_q != ST_FLUSH && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
            if (state_q == ST_WAIT && wait_cnt != 16'hFFFF)
                wait_cnt <= wait_cnt + 16'd1;
        end
    end
`endif

endmodule
